// File: rtl/snake_game_ctrl_pkg.sv
// Shared encodings and default sizing for the snake game-level controller.
// Pause support is selected by SNAKE_CTRL_PAUSE_EN in the modules that import this package.
package snake_game_ctrl_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    localparam int unsigned DEF_DIV_SLOW  = 12_500_000;
    localparam int unsigned DEF_DIV_NORM  = 6_250_000;
    localparam int unsigned DEF_DIV_FAST  = 3_125_000;
    localparam int unsigned DEF_CNT_W     = 24;
    localparam int unsigned DEF_INIT_LEN  = 3;
    localparam int unsigned DEF_MAX_LEN   = 255;
    localparam int unsigned DEF_SCORE_MAX = 9999;
    localparam int unsigned SCORE_W       = 14;
    localparam int unsigned LEN_W         = 8;

    function automatic dir_e opposite_dir(input dir_e d);
        case (d)
            DIR_UP:   opposite_dir = DIR_DOWN;
            DIR_DOWN: opposite_dir = DIR_UP;
            DIR_LEFT: opposite_dir = DIR_RIGHT;
            default:  opposite_dir = DIR_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/snake_game_ctrl_if.sv
// Key/datapath-facing signal bundle of the snake game controller.
// master drives keys and datapath events; slave is the controller.
interface snake_game_ctrl_if;
    import snake_game_ctrl_pkg::*;

    logic                 key_u;
    logic                 key_d;
    logic                 key_l;
    logic                 key_r;
    logic                 key_p;
    logic [1:0]           speed_mode;
    logic                 eat;
    logic                 hit;
    logic                 move_tick;
    dir_e                 dir;
    state_e               state;
    logic                 game_over;
    logic [SCORE_W-1:0]   score;
    logic [LEN_W-1:0]     length;

    modport master (
        output key_u, key_d, key_l, key_r, key_p, speed_mode, eat, hit,
        input  move_tick, dir, state, game_over, score, length
    );

    modport slave (
        input  key_u, key_d, key_l, key_r, key_p, speed_mode, eat, hit,
        output move_tick, dir, state, game_over, score, length
    );

endinterface

// File: rtl/snake_game_ctrl_tick_gen.sv
// Move-rate divider: counts while run is high and emits a registered one-cycle tick.
// due flags the cycle whose clock edge produces the tick, so the caller can commit with it.
module snake_game_ctrl_tick_gen #(
    parameter int unsigned DIV_SLOW = 8,
    parameter int unsigned DIV_NORM = 4,
    parameter int unsigned DIV_FAST = 2,
    parameter int unsigned CNT_W    = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       clear,
    input  logic [1:0] speed_mode,
    output logic       due,
    output logic       tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_m1;
    logic             tick_q, tick_d;

    always_comb begin
        case (speed_mode)
            2'b00:   div_m1 = CNT_W'(DIV_SLOW - 1);
            2'b01:   div_m1 = CNT_W'(DIV_NORM - 1);
            default: div_m1 = CNT_W'(DIV_FAST - 1);
        endcase
    end

    // >= rather than == so a switch to a faster mode never skips past the terminal count
    assign due = run && !clear && (cnt_q >= div_m1);

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (due) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else if (run) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: game FSM, direction arbitration, score/length counters.
// Define SNAKE_CTRL_PAUSE_EN to enable the PAUSE state via key_p.
//
// state    | meaning
// ST_IDLE  | waiting for a direction key; score/length at start values
// ST_PLAY  | snake moving, ticks generated, keys/eat/hit honoured
// ST_PAUSE | divider frozen, all game inputs except key_p ignored
// ST_OVER  | collision seen; results frozen until a direction key
module snake_game_ctrl
    import snake_game_ctrl_pkg::*;
#(
    parameter int unsigned DIV_SLOW  = DEF_DIV_SLOW,
    parameter int unsigned DIV_NORM  = DEF_DIV_NORM,
    parameter int unsigned DIV_FAST  = DEF_DIV_FAST,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned INIT_LEN  = DEF_INIT_LEN,
    parameter int unsigned MAX_LEN   = DEF_MAX_LEN,
    parameter int unsigned SCORE_MAX = DEF_SCORE_MAX
) (
    input  logic               clk,
    input  logic               rst,
    snake_game_ctrl_if.slave   bus
);

    state_e             state_q, state_d;
    dir_e               dir_q, dir_d;
    dir_e               pending_q, pending_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [LEN_W-1:0]   length_q, length_d;
    logic               key_any;
    dir_e               key_dir;
    logic               tick_run, tick_clear, tick_due, tick;
    logic               pause_key;

`ifdef SNAKE_CTRL_PAUSE_EN
    assign pause_key = bus.key_p;
`else
    logic unused_key_p;
    assign unused_key_p = bus.key_p;
    assign pause_key    = 1'b0;
`endif

    assign key_any = bus.key_u | bus.key_d | bus.key_l | bus.key_r;

    always_comb begin
        if (bus.key_u)      key_dir = DIR_UP;
        else if (bus.key_d) key_dir = DIR_DOWN;
        else if (bus.key_l) key_dir = DIR_LEFT;
        else                key_dir = DIR_RIGHT;
    end

    // hit wins over a due tick, so the divider is stopped in the collision cycle
    assign tick_run   = (state_q == ST_PLAY) && !bus.hit;
    assign tick_clear = (state_q == ST_IDLE) || (state_q == ST_OVER);

    snake_game_ctrl_tick_gen #(
        .DIV_SLOW (DIV_SLOW),
        .DIV_NORM (DIV_NORM),
        .DIV_FAST (DIV_FAST),
        .CNT_W    (CNT_W)
    ) u_tick_gen (
        .clk        (clk),
        .rst        (rst),
        .run        (tick_run),
        .clear      (tick_clear),
        .speed_mode (bus.speed_mode),
        .due        (tick_due),
        .tick       (tick)
    );

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        pending_d = pending_q;
        score_d   = score_q;
        length_d  = length_q;
        case (state_q)
            ST_IDLE: begin
                if (key_any) begin
                    state_d   = ST_PLAY;
                    dir_d     = key_dir;
                    pending_d = key_dir;
                end
            end
            ST_PLAY: begin
                if (bus.hit) begin
                    state_d = ST_OVER;
                end else begin
                    if (pause_key) state_d = ST_PAUSE;
                    if (tick_due) dir_d = pending_q;
                    // reversal is judged against the committed heading, not the queued one
                    if (key_any && (key_dir != opposite_dir(dir_q))) pending_d = key_dir;
                    if (bus.eat) begin
                        if (score_q < SCORE_W'(SCORE_MAX)) score_d = score_q + SCORE_W'(1);
                        if (length_q < LEN_W'(MAX_LEN)) length_d = length_q + LEN_W'(1);
                    end
                end
            end
            ST_PAUSE: begin
`ifdef SNAKE_CTRL_PAUSE_EN
                if (pause_key) state_d = ST_PLAY;
`else
                state_d = ST_IDLE;
`endif
            end
            ST_OVER: begin
                if (key_any) begin
                    state_d   = ST_IDLE;
                    dir_d     = DIR_RIGHT;
                    pending_d = DIR_RIGHT;
                    score_d   = '0;
                    length_d  = LEN_W'(INIT_LEN);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            dir_q     <= DIR_RIGHT;
            pending_q <= DIR_RIGHT;
            score_q   <= '0;
            length_q  <= LEN_W'(INIT_LEN);
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            pending_q <= pending_d;
            score_q   <= score_d;
            length_q  <= length_d;
        end
    end

    assign bus.move_tick = tick;
    assign bus.dir       = dir_q;
    assign bus.state     = state_q;
    assign bus.game_over = (state_q == ST_OVER);
    assign bus.score     = score_q;
    assign bus.length    = length_q;

endmodule
